// File: rtl/para_shift_tx.sv
// para_shift_tx: parallel-to-serial transmitter with valid/ready handshakes on both sides.
module para_shift_tx #(
    parameter int W         = 32,
    parameter bit MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] par_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t       state, state_nx;
    logic [W-1:0] sreg, sreg_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic         xfer, last, load;
    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        cnt_nx     = cnt;
        xfer       = (state == SHIFT) && ser_ready;
        last       = xfer && (cnt == CW'(W - 1));
        load_ready = (state == IDLE) || last;
        load       = load_valid && load_ready;
        ser_valid  = state == SHIFT;
        busy       = state == SHIFT;
        ser_out    = (state == SHIFT) && (MSB_FIRST ? sreg[W-1] : sreg[0]);
        // a load on the last-bit transfer overrides the shift so the next word follows with no gap
        if (load) begin
            state_nx = SHIFT;
            sreg_nx  = par_in;
            cnt_nx   = '0;
        end else if (xfer) begin
            sreg_nx  = MSB_FIRST ? {sreg[W-2:0], 1'b0} : {1'b0, sreg[W-1:1]};
            cnt_nx   = last ? '0 : cnt + 1'b1;
            state_nx = last ? IDLE : SHIFT;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            cnt   <= cnt_nx;
            done  <= last;
        end
    end
endmodule

// File: tb/tb_para_shift_tx.sv
// tb_para_shift_tx: directed checks of para_shift_tx in MSB-first/LSB-first W=8 and W=32 builds.
module tb_para_shift_tx;
    logic clk, rst_n;
    logic [7:0]  p8, pl;
    logic [31:0] p32;
    logic lv8, sr8, lr8, so8, sv8, b8, d8;
    logic lvl, srl, lrl, sol, svl, bl, dl;
    logic lv32, sr32, lr32, so32, sv32, b32, d32;
    int checks = 0;
    int errors = 0;

    para_shift_tx #(.W(8), .MSB_FIRST(1)) u8 (
        .clk(clk), .rst_n(rst_n), .par_in(p8), .load_valid(lv8), .load_ready(lr8),
        .ser_out(so8), .ser_valid(sv8), .ser_ready(sr8), .busy(b8), .done(d8));
    para_shift_tx #(.W(8), .MSB_FIRST(0)) ul (
        .clk(clk), .rst_n(rst_n), .par_in(pl), .load_valid(lvl), .load_ready(lrl),
        .ser_out(sol), .ser_valid(svl), .ser_ready(srl), .busy(bl), .done(dl));
    para_shift_tx #(.W(32), .MSB_FIRST(1)) u32 (
        .clk(clk), .rst_n(rst_n), .par_in(p32), .load_valid(lv32), .load_ready(lr32),
        .ser_out(so32), .ser_valid(sv32), .ser_ready(sr32), .busy(b32), .done(d32));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  v;
        logic [31:0] w;
        int cyc;
        rst_n = 0; p8 = 0; pl = 0; p32 = 0;
        lv8 = 0; sr8 = 0; lvl = 0; srl = 0; lv32 = 0; sr32 = 0;
        // load attempted while in reset must be ignored
        p8 = 8'hA5; lv8 = 1; sr8 = 1;
        tick(); tick();
        lv8 = 0;
        chk("rst_valid", sv8, 0);
        chk("rst_busy", b8, 0);
        chk("rst_done", d8, 0);
        chk("rst_ready", lr8, 1);
        chk("rst_out", so8, 0);
        chk("rst_ready32", lr32, 1);
        rst_n = 1;
        tick();
        chk("idle_after_rst_load", sv8, 0);

        // 0xA5 MSB first, ready held high
        v = 8'hA5; p8 = v; lv8 = 1; sr8 = 1;
        tick();
        lv8 = 0; p8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("a5_bit", so8, v[7-i]);
            chk("a5_valid", sv8, 1);
            chk("a5_busy", b8, 1);
            chk("a5_done_low", d8, 0);
            chk("a5_ready", lr8, i == 7);
            tick();
        end
        chk("a5_done", d8, 1);
        chk("a5_busy_end", b8, 0);
        chk("a5_valid_end", sv8, 0);
        tick();
        chk("a5_done_pulse", d8, 0);

        // 0x01 LSB first
        v = 8'h01; pl = v; lvl = 1; srl = 1;
        tick();
        lvl = 0;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_bit", sol, v[i]);
            tick();
        end
        chk("lsb_done", dl, 1);

        // 0xF0 with a 3-cycle stall after the second bit
        v = 8'hF0; p8 = v; lv8 = 1; sr8 = 1;
        tick();
        lv8 = 0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                sr8 = 0;
                for (int s = 0; s < 3; s++) begin
                    chk("stall_out", so8, 1);
                    chk("stall_ready", lr8, 0);
                    chk("stall_busy", b8, 1);
                    tick();
                    cyc++;
                end
                sr8 = 1;
            end
            chk("stall_bit", so8, v[7-i]);
            tick();
            cyc++;
        end
        chk("stall_cycles", cyc, 11);
        chk("stall_done", d8, 1);
        chk("stall_idle", b8, 0);
        tick();

        // 0xFF then 0x00 back to back
        p8 = 8'hFF; lv8 = 1; sr8 = 1;
        tick();
        lv8 = 0;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_first", so8, 1);
            chk("b2b_valid1", sv8, 1);
            if (i == 7) begin
                p8 = 8'h00; lv8 = 1;
                #1 chk("b2b_ready_last", lr8, 1);
            end
            tick();
        end
        lv8 = 0; p8 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_second", so8, 0);
            chk("b2b_valid2", sv8, 1);
            chk("b2b_done_mid", d8, i == 0);
            tick();
        end
        chk("b2b_done_end", d8, 1);
        chk("b2b_idle", b8, 0);
        tick();

        // par_in churn during a word in flight
        v = 8'h3C; p8 = v; lv8 = 1; sr8 = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            p8 = 8'($urandom);
            lv8 = (i < 7);
            #1;
            if (i < 7) chk("churn_ready", lr8, 0);
            chk("churn_bit", so8, v[7-i]);
            tick();
        end
        lv8 = 0;
        chk("churn_done", d8, 1);
        tick();

        // reset mid-word on the 32-bit build
        w = 32'hDEADBEEF; p32 = w; lv32 = 1; sr32 = 1;
        tick();
        lv32 = 0;
        for (int i = 0; i < 5; i++) begin
            chk("w32_pre", so32, w[31-i]);
            tick();
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("w32_rst_valid", sv32, 0);
        chk("w32_rst_busy", b32, 0);
        chk("w32_rst_done", d32, 0);
        chk("w32_rst_ready", lr32, 1);
        tick();
        chk("w32_no_done", d32, 0);
        chk("w32_still_idle", sv32, 0);
        w = 32'h80000001; p32 = w; lv32 = 1;
        tick();
        lv32 = 0;
        for (int i = 0; i < 32; i++) begin
            chk("w32_bit", so32, w[31-i]);
            chk("w32_busy", b32, 1);
            tick();
        end
        chk("w32_done", d32, 1);
        chk("w32_idle", b32, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
